onehot_decoder_scan: RTL



---
 rtl/onehot_decoder_scan_pkg.sv | 14 +
 rtl/onehot_decoder_scan_prescaler.sv | 18 +
 rtl/onehot_decoder_scan.sv | 81 ++++++++
 3 files changed

// File: rtl/onehot_decoder_scan_pkg.sv
// decoder_pkg: state encoding, truncated one-hot helper and parameter checks
// shared by the one-hot decoder and its scan prescaler.
package decoder_pkg;
  localparam int unsigned MAX_N = 256;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  function automatic logic [MAX_N-1:0] onehot(input int unsigned code, input int unsigned n);
    return (code < n) ? MAX_N'(1) << code : '0;
  endfunction
  function automatic bit params_ok(input int unsigned in_w, input int unsigned out_n,
                                   input int unsigned scan_div);
    return in_w >= 1 && out_n >= 2 && out_n <= MAX_N && scan_div >= 1 &&
           (in_w >= 32 || out_n <= (32'd1 << in_w));
  endfunction
endpackage

// File: rtl/onehot_decoder_scan_prescaler.sv
// scan_prescaler: counts 0..DIV-1 and ticks on the terminal count; clear
// holds it at zero so a new scan always starts on a full step.
module scan_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = r_cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_clr || o_tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/onehot_decoder_scan.sv
// onehot_decoder_scan: registered binary-to-one-hot decoder with a valid/ready
// input, sticky out-of-range flag and an autonomous scanning mode.
module onehot_decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W     = 4,
  parameter int unsigned OUT_N    = 10,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic             err_clr,
  output logic [OUT_N-1:0] y,
  output logic             y_valid,
  output logic [IN_W-1:0]  idx,
  output logic             err
);
  if (!params_ok(IN_W, OUT_N, SCAN_DIV)) begin : g_bad_params
    $error("onehot_decoder_scan: illegal IN_W/OUT_N/SCAN_DIV");
  end
  state_t           r_state, w_next;
  logic [OUT_N-1:0] r_y;
  logic [IN_W-1:0]  r_idx, w_idx_next;
  logic             r_y_valid, r_err;
  logic             w_hs, w_oob, w_tick, w_scan_entry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = IDLE;
    if (en) w_next = mode ? SCAN : DIRECT;
  end
  assign in_ready     = r_state == DIRECT;
  assign w_hs         = in_valid & in_ready;
  assign w_oob        = {1'b0, a} >= (IN_W + 1)'(OUT_N);
  assign w_scan_entry = r_state != SCAN;
  assign w_idx_next   = (r_idx == IN_W'(OUT_N - 1)) ? '0 : r_idx + 1'b1;
  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_scan_entry),
    .o_tick (w_tick)
  );
  // Leaving SCAN for DIRECT falls through every branch, so the last scan output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= (w_hs & w_oob) | (r_err & ~err_clr);
      if (!en) begin
        r_y       <= '0;
        r_y_valid <= 1'b0;
        r_idx     <= '0;
      end else if (mode && w_scan_entry) begin
        r_y       <= OUT_N'(onehot(0, OUT_N));
        r_y_valid <= 1'b1;
        r_idx     <= '0;
      end else if (mode && w_tick) begin
        r_y   <= OUT_N'(onehot(32'(w_idx_next), OUT_N));
        r_idx <= w_idx_next;
      end else if (!mode && w_hs) begin
        r_y       <= OUT_N'(onehot(32'(a), OUT_N));
        r_y_valid <= ~w_oob;
        r_idx     <= a;
      end
    end
  end
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign idx     = r_idx;
  assign err     = r_err;
endmodule
